// File: rtl/tlb_if.sv
// ============================================================================
// Module   : tlb_if
// Brief    : Bundle of TLB lookup, probe, write and read-port signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlb_if #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
);
    logic                    s0_req, s0_odd_page, s0_valid, s0_found, s0_d, s0_v;
    logic [18:0]             s0_vpn2;
    logic [7:0]              s0_asid;
    logic [TLBNUM_WIDTH-1:0] s0_index;
    logic [19:0]             s0_pfn;
    logic [2:0]              s0_c;

    logic                    s1_req, s1_odd_page, s1_valid, s1_found, s1_d, s1_v;
    logic [18:0]             s1_vpn2;
    logic [7:0]              s1_asid;
    logic [TLBNUM_WIDTH-1:0] s1_index;
    logic [19:0]             s1_pfn;
    logic [2:0]              s1_c;

    logic                    p_req, p_valid;
    logic [18:0]             p_vpn2;
    logic [7:0]              p_asid;
    logic [TLBNUM_WIDTH:0]   p_result;

    logic                    we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [TLBNUM_WIDTH-1:0] w_index;
    logic [18:0]             w_vpn2;
    logic [7:0]              w_asid;
    logic [19:0]             w_pfn0, w_pfn1;
    logic [2:0]              w_c0, w_c1;

    logic [TLBNUM_WIDTH-1:0] r_index;
    logic                    r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0]             r_vpn2;
    logic [7:0]              r_asid;
    logic [19:0]             r_pfn0, r_pfn1;
    logic [2:0]              r_c0, r_c1;

    modport master (
        output s0_req, s0_vpn2, s0_odd_page, s0_asid,
        input  s0_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_req, s1_vpn2, s1_odd_page, s1_asid,
        input  s1_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output p_req, p_vpn2, p_asid,
        input  p_valid, p_result,
        output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
        output w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );

    modport slave (
        input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
        output s0_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
        output s1_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  p_req, p_vpn2, p_asid,
        output p_valid, p_result,
        input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
        input  w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );
endinterface

`default_nettype wire

// File: rtl/tlb.sv
// ============================================================================
// Module   : tlb
// Brief    : Fully associative dual-page TLB, two lookup ports plus a probe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  wire logic clk,
    input  wire logic resetn,
    tlb_if.slave      bus
);
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } page_t;

    localparam page_t                 c_PAGE_NONE = '0;
    localparam logic [TLBNUM_WIDTH:0] c_P_MISS    = {1'b1, {TLBNUM_WIDTH{1'b0}}};

    logic [TLBNUM-1:0] r_e;
    logic [TLBNUM-1:0] r_g;
    logic [18:0]       r_ent_vpn2 [TLBNUM];
    logic [7:0]        r_ent_asid [TLBNUM];
    page_t             r_ent_pg0  [TLBNUM];
    page_t             r_ent_pg1  [TLBNUM];

    function automatic logic [TLBNUM-1:0] f_match(input logic [18:0] vpn2, input logic [7:0] asid);
        f_match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            f_match[i] = r_e[i] && (r_ent_vpn2[i] == vpn2) && (r_g[i] || (r_ent_asid[i] == asid));
        end
    endfunction

    // Walk downward so the lowest matching index is the one left standing.
    function automatic logic [TLBNUM_WIDTH-1:0] f_encode(input logic [TLBNUM-1:0] m);
        f_encode = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) f_encode = TLBNUM_WIDTH'(i);
        end
    endfunction

    logic [TLBNUM-1:0]       w_s0_match, w_s1_match, w_p_match;
    logic [TLBNUM_WIDTH-1:0] w_s0_idx, w_s1_idx, w_p_idx;
    logic                    w_s0_hit, w_s1_hit, w_p_hit;
    page_t                   w_s0_pg, w_s1_pg;

    always_comb begin
        w_s0_match = f_match(bus.s0_vpn2, bus.s0_asid);
        w_s1_match = f_match(bus.s1_vpn2, bus.s1_asid);
        w_p_match  = f_match(bus.p_vpn2, bus.p_asid);
        w_s0_hit   = |w_s0_match;
        w_s1_hit   = |w_s1_match;
        w_p_hit    = |w_p_match;
        w_s0_idx   = f_encode(w_s0_match);
        w_s1_idx   = f_encode(w_s1_match);
        w_p_idx    = f_encode(w_p_match);
        w_s0_pg    = bus.s0_odd_page ? r_ent_pg1[w_s0_idx] : r_ent_pg0[w_s0_idx];
        w_s1_pg    = bus.s1_odd_page ? r_ent_pg1[w_s1_idx] : r_ent_pg0[w_s1_idx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_e <= '0;
            r_g <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                r_ent_vpn2[i] <= '0;
                r_ent_asid[i] <= '0;
                r_ent_pg0[i]  <= c_PAGE_NONE;
                r_ent_pg1[i]  <= c_PAGE_NONE;
            end
        end else if (bus.we) begin
            r_e[bus.w_index]        <= 1'b1;
            r_g[bus.w_index]        <= bus.w_g;
            r_ent_vpn2[bus.w_index] <= bus.w_vpn2;
            r_ent_asid[bus.w_index] <= bus.w_asid;
            r_ent_pg0[bus.w_index]  <= '{pfn: bus.w_pfn0, c: bus.w_c0, d: bus.w_d0, v: bus.w_v0};
            r_ent_pg1[bus.w_index]  <= '{pfn: bus.w_pfn1, c: bus.w_c1, d: bus.w_d1, v: bus.w_v1};
        end
    end

    logic                    r_s0_valid, r_s0_found, r_s1_valid, r_s1_found, r_p_valid;
    logic [TLBNUM_WIDTH-1:0] r_s0_index, r_s1_index;
    page_t                   r_s0_pg, r_s1_pg;
    logic [TLBNUM_WIDTH:0]   r_p_result;

    // Result fields only update on a request so they hold between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s0_valid <= 1'b0;
            r_s0_found <= 1'b0;
            r_s0_index <= '0;
            r_s0_pg    <= c_PAGE_NONE;
            r_s1_valid <= 1'b0;
            r_s1_found <= 1'b0;
            r_s1_index <= '0;
            r_s1_pg    <= c_PAGE_NONE;
            r_p_valid  <= 1'b0;
            r_p_result <= c_P_MISS;
        end else begin
            r_s0_valid <= bus.s0_req;
            r_s1_valid <= bus.s1_req;
            r_p_valid  <= bus.p_req;
            if (bus.s0_req) begin
                r_s0_found <= w_s0_hit;
                r_s0_index <= w_s0_hit ? w_s0_idx : '0;
                r_s0_pg    <= w_s0_hit ? w_s0_pg : c_PAGE_NONE;
            end
            if (bus.s1_req) begin
                r_s1_found <= w_s1_hit;
                r_s1_index <= w_s1_hit ? w_s1_idx : '0;
                r_s1_pg    <= w_s1_hit ? w_s1_pg : c_PAGE_NONE;
            end
            if (bus.p_req) begin
                r_p_result <= {~w_p_hit, (w_p_hit ? w_p_idx : {TLBNUM_WIDTH{1'b0}})};
            end
        end
    end

    assign bus.s0_valid = r_s0_valid;
    assign bus.s0_found = r_s0_found;
    assign bus.s0_index = r_s0_index;
    assign bus.s0_pfn   = r_s0_pg.pfn;
    assign bus.s0_c     = r_s0_pg.c;
    assign bus.s0_d     = r_s0_pg.d;
    assign bus.s0_v     = r_s0_pg.v;
    assign bus.s1_valid = r_s1_valid;
    assign bus.s1_found = r_s1_found;
    assign bus.s1_index = r_s1_index;
    assign bus.s1_pfn   = r_s1_pg.pfn;
    assign bus.s1_c     = r_s1_pg.c;
    assign bus.s1_d     = r_s1_pg.d;
    assign bus.s1_v     = r_s1_pg.v;
    assign bus.p_valid  = r_p_valid;
    assign bus.p_result = r_p_result;

    logic  w_rd_e;
    page_t w_rd_pg0, w_rd_pg1;

    // Unoccupied entries read back as all zeros regardless of stored contents.
    assign w_rd_e      = r_e[bus.r_index];
    assign w_rd_pg0    = w_rd_e ? r_ent_pg0[bus.r_index] : c_PAGE_NONE;
    assign w_rd_pg1    = w_rd_e ? r_ent_pg1[bus.r_index] : c_PAGE_NONE;
    assign bus.r_vpn2  = w_rd_e ? r_ent_vpn2[bus.r_index] : 19'd0;
    assign bus.r_asid  = w_rd_e ? r_ent_asid[bus.r_index] : 8'd0;
    assign bus.r_g     = w_rd_e & r_g[bus.r_index];
    assign bus.r_pfn0  = w_rd_pg0.pfn;
    assign bus.r_c0    = w_rd_pg0.c;
    assign bus.r_d0    = w_rd_pg0.d;
    assign bus.r_v0    = w_rd_pg0.v;
    assign bus.r_pfn1  = w_rd_pg1.pfn;
    assign bus.r_c1    = w_rd_pg1.c;
    assign bus.r_d1    = w_rd_pg1.d;
    assign bus.r_v1    = w_rd_pg1.v;

endmodule

`default_nettype wire

// File: tb/tb_tlb.sv
// ============================================================================
// Module   : tb_tlb
// Brief    : Directed scoreboard bench for the tlb block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb;
    localparam int TLBNUM = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_if #(.TLBNUM(TLBNUM)) bus ();
    tlb #(.TLBNUM(TLBNUM)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic        found;
        logic [3:0]  index;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [4:0] qp[$];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    function automatic exp_t mk(logic f, logic [3:0] i, logic [19:0] p, logic [2:0] c, logic d, logic v);
        exp_t e;
        e.found = f; e.index = i; e.pfn = p; e.c = c; e.d = d; e.v = v;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lookup(input string port, input logic valid, input logic found,
                                input logic [3:0] index, input logic [19:0] pfn, input logic [2:0] c,
                                input logic d, input logic v, input exp_t e);
        check({port, "_valid"}, valid, 1);
        check({port, "_found"}, found, e.found);
        check({port, "_index"}, index, e.index);
        check({port, "_pfn"},   pfn,   e.pfn);
        check({port, "_c"},     c,     e.c);
        check({port, "_d"},     d,     e.d);
        check({port, "_v"},     v,     e.v);
    endtask

    task automatic idle_inputs();
        bus.s0_req = 1'b0;
        bus.s1_req = 1'b0;
        bus.p_req  = 1'b0;
        bus.we     = 1'b0;
    endtask

    task automatic look(input int port, input logic [18:0] vpn2, input logic odd,
                        input logic [7:0] asid, input exp_t e);
        if (port == 0) begin
            bus.s0_req = 1'b1; bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
            q0.push_back(e);
        end else begin
            bus.s1_req = 1'b1; bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
            q1.push_back(e);
        end
    endtask

    task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid, input logic [4:0] e);
        bus.p_req = 1'b1; bus.p_vpn2 = vpn2; bus.p_asid = asid;
        qp.push_back(e);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                      input logic v0, input logic [19:0] pfn1, input logic [2:0] c1, input logic d1,
                      input logic v1);
        bus.we = 1'b1; bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
        bus.w_pfn0 = pfn0; bus.w_c0 = c0; bus.w_d0 = d0; bus.w_v0 = v0;
        bus.w_pfn1 = pfn1; bus.w_c1 = c1; bus.w_d1 = d1; bus.w_v1 = v1;
    endtask

    // One clock: responses for requests driven before this edge are due now.
    task automatic step();
        exp_t       e;
        logic [4:0] pe;
        @(posedge clk);
        #1;
        idle_inputs();
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_lookup("s0", bus.s0_valid, bus.s0_found, bus.s0_index, bus.s0_pfn,
                         bus.s0_c, bus.s0_d, bus.s0_v, e);
        end else check("s0_valid_idle", bus.s0_valid, 0);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_lookup("s1", bus.s1_valid, bus.s1_found, bus.s1_index, bus.s1_pfn,
                         bus.s1_c, bus.s1_d, bus.s1_v, e);
        end else check("s1_valid_idle", bus.s1_valid, 0);
        if (qp.size() > 0) begin
            pe = qp.pop_front();
            check("p_valid", bus.p_valid, 1);
            check("p_result", bus.p_result, pe);
        end else check("p_valid_idle", bus.p_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t miss;
        miss = mk(0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        idle_inputs();
        bus.s0_vpn2 = '0; bus.s0_odd_page = 0; bus.s0_asid = '0;
        bus.s1_vpn2 = '0; bus.s1_odd_page = 0; bus.s1_asid = '0;
        bus.p_vpn2 = '0; bus.p_asid = '0; bus.r_index = '0;
        wr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.we = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_s0_valid", bus.s0_valid, 0);
        check("rst_s1_valid", bus.s1_valid, 0);
        check("rst_p_valid", bus.p_valid, 0);
        check("rst_s0_found", bus.s0_found, 0);
        check("rst_s1_pfn", bus.s1_pfn, 0);
        check("rst_p_result", bus.p_result, 5'h10);
        check("rst_r_vpn2", bus.r_vpn2, 0);
        @(negedge clk);
        resetn = 1'b1;

        look(0, 19'h0, 0, 8'h0, miss);
        probe(19'h0, 8'h0, 5'h10);
        step();

        wr(3, 19'h00400, 8'h05, 0, 20'h00111, 3'd2, 0, 1, 20'h00222, 3'd3, 1, 1);
        step();
        bus.r_index = 4'd3;
        #1;
        check("r_vpn2", bus.r_vpn2, 19'h00400);
        check("r_asid", bus.r_asid, 8'h05);
        check("r_g", bus.r_g, 0);
        check("r_pfn0", bus.r_pfn0, 20'h00111);
        check("r_c0", bus.r_c0, 3'd2);
        check("r_v0", bus.r_v0, 1);
        check("r_pfn1", bus.r_pfn1, 20'h00222);
        check("r_c1", bus.r_c1, 3'd3);
        check("r_d1", bus.r_d1, 1);
        check("r_v1", bus.r_v1, 1);

        look(1, 19'h00400, 1, 8'h05, mk(1, 3, 20'h00222, 3'd3, 1, 1));
        look(0, 19'h00400, 0, 8'h05, mk(1, 3, 20'h00111, 3'd2, 0, 1));
        step();
        look(1, 19'h00400, 1, 8'h06, miss);
        step();
        check("s0_hold_found", bus.s0_found, 1);
        check("s0_hold_pfn", bus.s0_pfn, 20'h00111);

        wr(7, 19'h12345, 8'h01, 1, 20'h0AAAA, 3'd1, 1, 1, 20'h0BBBB, 3'd0, 0, 1);
        step();
        probe(19'h12345, 8'hAA, 5'h07);
        look(0, 19'h12345, 0, 8'h33, mk(1, 7, 20'h0AAAA, 3'd1, 1, 1));
        look(1, 19'h12345, 1, 8'hFE, mk(1, 7, 20'h0BBBB, 3'd0, 0, 1));
        step();

        wr(9, 19'h55555, 8'h10, 0, 20'h09009, 3'd0, 0, 1, 20'h09109, 3'd0, 0, 1);
        step();
        wr(2, 19'h55555, 8'h10, 0, 20'h02002, 3'd4, 0, 1, 20'h02102, 3'd5, 1, 0);
        step();
        look(0, 19'h55555, 1, 8'h10, mk(1, 2, 20'h02102, 3'd5, 1, 0));
        probe(19'h55555, 8'h10, 5'h02);
        step();

        bus.r_index = 4'd4;
        wr(4, 19'h0ABCD, 8'h20, 0, 20'h44444, 3'd6, 1, 1, 20'h48888, 3'd7, 0, 1);
        look(0, 19'h0ABCD, 0, 8'h20, miss);
        probe(19'h0ABCD, 8'h20, 5'h10);
        #1;
        check("r_vpn2_before_write", bus.r_vpn2, 0);
        step();
        check("r_vpn2_after_write", bus.r_vpn2, 19'h0ABCD);
        look(0, 19'h0ABCD, 0, 8'h20, mk(1, 4, 20'h44444, 3'd6, 1, 1));
        probe(19'h55555, 8'h11, 5'h10);
        step();

        bus.r_index = 4'd3;
        look(1, 19'h00400, 0, 8'h05, mk(1, 3, 20'h00111, 3'd2, 0, 1));
        step();
        bus.s0_req = 1'b1; bus.s0_vpn2 = 19'h00400; bus.s0_odd_page = 0; bus.s0_asid = 8'h05;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_s1_valid", bus.s1_valid, 0);
        check("arst_s1_found", bus.s1_found, 0);
        check("arst_s1_pfn", bus.s1_pfn, 0);
        check("arst_p_result", bus.p_result, 5'h10);
        check("arst_r_vpn2", bus.r_vpn2, 0);
        check("arst_r_pfn0", bus.r_pfn0, 0);
        @(posedge clk);
        #1;
        check("arst_s0_valid", bus.s0_valid, 0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        step();
        look(0, 19'h00400, 0, 8'h05, miss);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
